rf_wb_arbiter: RTL
==================

// Module: rf_wb_arbiter
// PURPOSE
//  Write-back arbiter/sequencer for the 32x8 register file's single write port.
//  Shares the port between the ALU result path and the load (LSU) path.
//  Sequences 16-bit register-pair writes (ADIW/SBIW/MOVW/MUL results) as two byte writes.
//  Drives the register file's en_WD/WD_addr/WD inputs directly.
// PARAMETERS
//  ADDR_W    5  register address width
//  DATA_W    8  register data width; ALU wide data is 2*DATA_W
//  ARB_MODE  0  0 = round-robin between ALU/LSU; 1 = fixed priority, LSU wins
// PORTS
//  clk        in   1         clock, all state on rising edge
//  rst        in   1         synchronous reset, active high
//  alu_valid  in   1         ALU write-back request
//  alu_ready  out  1         ALU request accepted this cycle (combinational)
//  alu_addr   in   ADDR_W    destination register (bit0 ignored when alu_wide)
//  alu_data   in   2*DATA_W  result; [DATA_W-1:0] = low byte
//  alu_wide   in   1         1 = pair write, low to even reg, high to even+1
//  lsu_valid  in   1         load write-back request
//  lsu_ready  out  1         load request accepted this cycle (combinational)
//  lsu_addr   in   ADDR_W    destination register
//  lsu_data   in   DATA_W    loaded byte
//  en_WD      out  1         register-file write enable (registered)
//  WD_addr    out  ADDR_W    register-file write address (registered)
//  WD         out  DATA_W    register-file write data (registered)
//  busy       out  1         high in WIDE_HI; decoder must stall on it
// BEHAVIOUR
//  - Reset: state=IDLE, en_WD=0, WD_addr=0, WD=0, last_grant=LSU, hi_buf=0; ready=0.
//  - Handshake: transfer when valid & ready on the same edge. Requester holds
//    valid/addr/data stable until ready. Ready never asserted in WIDE_HI or rst.
//  - IDLE: one request -> grant it. Both valid -> ARB_MODE=1: LSU;
//    ARB_MODE=0: the one not in last_grant, then last_grant updates to winner.
//    Single-requester grants also update last_grant.
//  - Accept at edge N: en_WD=1, WD_addr, WD valid during cycle N+1; regfile
//    writes at edge N+2. No request -> en_WD=0 next cycle (WD_addr/WD hold).
//  - Narrow accept: WD_addr=addr, WD=data[DATA_W-1:0]; stay IDLE.
//  - Wide ALU accept: WD_addr={addr[ADDR_W-1:1],0}, WD=low byte; high byte
//    latched in hi_buf; go WIDE_HI.
//  - WIDE_HI (one cycle): en_WD=1, WD_addr={addr[ADDR_W-1:1],1}, WD=hi_buf;
//    no grants; return IDLE. Back-to-back wide ops: 1 write/cycle, accept every 2 cycles.
//  - Throughput: narrow requests accepted every cycle, one write per cycle.
//  - Wide with addr=31 writes R30 then R31 (no wrap past 31).
//  - Same-address back-to-back writes both issued in order; last one wins.
//  - rst in WIDE_HI: high byte dropped, en_WD=0 next cycle, state IDLE.
//  - rst same cycle as valid: no accept, ready=0.
//  - busy = (state==WIDE_HI), combinational from state.
// TESTING
//  1 Reset: hold rst 2 cycles with both valid -> readies 0, en_WD=0, WD_addr=0, WD=0.
//  2 Narrow ALU R5=0x3C at edge N -> en_WD=1, WD_addr=5, WD=0x3C in cycle N+1; regfile R5=0x3C.
//  3 Wide ALU addr=25, data=0xBEEF -> cycle N+1 R24<=0xEF, N+2 R25<=0xBE, busy high in N+1, readies 0.
//  4 ARB_MODE=0, both valid 4 cycles (ALU R1, LSU R2) -> grants ALU,LSU,ALU,LSU; ARB_MODE=1 -> LSU every cycle.
//  5 rst asserted in WIDE_HI of wide write to R26 -> R26 written, R27 unchanged, en_WD=0 after.
//  6 Wide addr=31 data=0x1234 -> R30=0x34, R31=0x12; next LSU R31=0x99 lands after -> R31=0x99.

Source files
------------

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: write-back arbiter and sequencer for the register file's
// single write port. It shares the port between the ALU result path and the
// load path. It splits 16-bit pair results into two byte writes, low byte first.
module rf_wb_arbiter #(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 8,
    parameter int ARB_MODE = 0    // 0 = round-robin, 1 = fixed priority (LSU wins)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [ADDR_W-1:0]     alu_addr,
    input  logic [2*DATA_W-1:0]   alu_data,
    input  logic                  alu_wide,
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic [ADDR_W-1:0]     lsu_addr,
    input  logic [DATA_W-1:0]     lsu_data,
    output logic                  en_WD,
    output logic [ADDR_W-1:0]     WD_addr,
    output logic [DATA_W-1:0]     WD,
    output logic                  busy
);

    typedef enum logic {IDLE, WIDE_HI} state_t;

    localparam logic GRANT_ALU = 1'b0;
    localparam logic GRANT_LSU = 1'b1;

    state_t              state, state_next;
    logic                last_grant, last_grant_next;
    logic [DATA_W-1:0]   hi_buf, hi_buf_next;
    logic                en_next;
    logic [ADDR_W-1:0]   addr_next;
    logic [DATA_W-1:0]   wd_next;
    logic                grant_alu, grant_lsu;

    // Arbitration: grants happen only in IDLE and never while reset is high.
    always_comb begin
        grant_alu = 1'b0;
        grant_lsu = 1'b0;
        if (!rst && state == IDLE) begin
            if (alu_valid && lsu_valid) begin
                if (ARB_MODE == 1)
                    grant_lsu = 1'b1;
                else if (last_grant == GRANT_LSU)
                    grant_alu = 1'b1;
                else
                    grant_lsu = 1'b1;
            end else begin
                grant_alu = alu_valid;
                grant_lsu = lsu_valid;
            end
        end
    end

    assign alu_ready = grant_alu;
    assign lsu_ready = grant_lsu;
    assign busy      = (state == WIDE_HI);

    // Next-state logic and the next register-file write. When nothing is
    // written, the address and data outputs hold their values.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
        state_next      = state;
        last_grant_next = last_grant;
        hi_buf_next     = hi_buf;
        en_next         = 1'b0;
        addr_next       = WD_addr;
        wd_next         = WD;
        case (state)
            IDLE: begin
                if (grant_alu) begin
                    last_grant_next = GRANT_ALU;
                    en_next         = 1'b1;
                    wd_next         = alu_data[DATA_W-1:0];
                    if (alu_wide) begin
                        addr_next   = {alu_addr[ADDR_W-1:1], 1'b0};
                        hi_buf_next = alu_data[2*DATA_W-1:DATA_W];
                        state_next  = WIDE_HI;
                    end else begin
                        addr_next   = alu_addr;
                    end
                end else if (grant_lsu) begin
                    last_grant_next = GRANT_LSU;
                    en_next         = 1'b1;
                    addr_next       = lsu_addr;
                    wd_next         = lsu_data;
                end
            end
            WIDE_HI: begin
                // The even address of the pair is still on WD_addr, so set bit 0 to get the odd address.
                en_next    = 1'b1;
                addr_next  = {WD_addr[ADDR_W-1:1], 1'b1};
                wd_next    = hi_buf;
                state_next = IDLE;
            end
        endcase
    end

    // State and registered write-port outputs, with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register updates from values sampled before the edge.
        if (rst) begin
            state      <= IDLE;
            last_grant <= GRANT_LSU;
            hi_buf     <= '0;
            en_WD      <= 1'b0;
            WD_addr    <= '0;
            WD         <= '0;
        end else begin
            state      <= state_next;
            last_grant <= last_grant_next;
            hi_buf     <= hi_buf_next;
            en_WD      <= en_next;
            WD_addr    <= addr_next;
            WD         <= wd_next;
        end
    end

endmodule
